// File: rtl/ols_deblock.sv
// ols_deblock -- output framer for the overlap-save FFT block LMS datapath.
//
// Accepts 2*BLK_LEN-sample complex frames from the IFFT. The first BLK_LEN
// samples of each frame (the circularly aliased half) are thrown away. The
// last BLK_LEN samples go into one bank of a two-bank ping-pong RAM. Each
// sample-rate out_req replays one stored sample, so the filter output is
// delivered at the input sample rate.
//
// Ports:
//   clk        processing clock (2x sample rate or faster)
//   reset      asynchronous, active-low reset
//   x_i, x_q   IFFT output sample (I/Q), qualified by in_valid
//   in_valid   x_i/x_q carry a sample this cycle
//   in_start   marks frame index 0 (qualified by in_valid)
//   out_req    one-cycle strobe requesting one output sample
//   y_i, y_q   output sample, valid one clock after an accepted out_req
//   out_valid  one-cycle pulse, y_i/y_q valid
//   blk_rdy    at least one bank holds a complete block (registered)
//   overrun    one-cycle pulse, an incoming frame was dropped
//   underrun   one-cycle pulse, out_req arrived with no full bank
//   frame_err  one-cycle pulse, in_start arrived in the middle of a frame
module ols_deblock #(
    parameter int BLK_LEN = 32,
    parameter int WIDTH   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] x_q,
    input  logic             in_valid,
    input  logic             in_start,
    input  logic             out_req,
    output logic [WIDTH-1:0] y_i,
    output logic [WIDTH-1:0] y_q,
    output logic             out_valid,
    output logic             blk_rdy,
    output logic             overrun,
    output logic             underrun,
    output logic             frame_err
);

    localparam int CW = $clog2(2 * BLK_LEN);   // frame index width
    localparam int AW = CW - 1;                // bank address width
    localparam logic [CW-1:0] LAST_IDX  = CW'(2 * BLK_LEN - 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(BLK_LEN - 1);

    typedef enum logic [1:0] {IDLE, FILL, DROP} wr_state_t;

    wr_state_t       state_reg, state_next;
    logic [CW-1:0]   wcnt_reg, wcnt_next;
    logic            wr_bank_reg, wr_bank_next;
    logic            rd_bank_reg, rd_bank_next;
    logic [AW-1:0]   raddr_reg, raddr_next;
    logic [1:0]      full_reg, full_next;

    logic            wr_en;
    logic            set_full;
    logic            start_ok;
    logic            overrun_next, frame_err_next;
    logic            rd_fire, rd_last, rd_under;

    logic [2*WIDTH-1:0] mem [0:2*BLK_LEN-1];
    logic [2*WIDTH-1:0] rd_data_reg;
    logic               y_zero_reg;
    logic               out_valid_reg, underrun_reg, overrun_reg;
    logic               frame_err_reg, blk_rdy_reg;

    // ---------------- read side ----------------
    assign rd_fire  = out_req & full_reg[rd_bank_reg];
    assign rd_under = out_req & ~full_reg[rd_bank_reg];
    assign rd_last  = rd_fire & (raddr_reg == LAST_ADDR);

    // BLK_LEN is a power of two, so the address wraps to 0 after the last read.
    assign raddr_next   = rd_fire ? raddr_reg + AW'(1) : raddr_reg;
    assign rd_bank_next = rd_last ? ~rd_bank_reg : rd_bank_reg;

    // A bank being drained by its final read this cycle is already free.
    assign start_ok = ~full_reg[wr_bank_reg] | (rd_last & (rd_bank_reg == wr_bank_reg));

    // ---------------- write FSM ----------------
    always_comb begin
        state_next     = state_reg;
        wcnt_next      = wcnt_reg;
        wr_bank_next   = wr_bank_reg;
        wr_en          = 1'b0;
        set_full       = 1'b0;
        overrun_next   = 1'b0;
        frame_err_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (in_valid && in_start) begin
                    wcnt_next = CW'(1);
                    if (start_ok) begin
                        state_next = FILL;
                    end else begin
                        state_next   = DROP;
                        overrun_next = 1'b1;
                    end
                end
            end
            FILL, DROP: begin
                if (in_valid) begin
                    if (in_start) begin
                        // Restart: the partial frame is abandoned and this
                        // sample becomes index 0 of a new frame.
                        frame_err_next = 1'b1;
                        wcnt_next      = CW'(1);
                        if (start_ok) begin
                            state_next = FILL;
                        end else begin
                            state_next   = DROP;
                            overrun_next = 1'b1;
                        end
                    end else begin
                        // Upper half of the frame has the MSB of wcnt set.
                        if (state_reg == FILL && wcnt_reg[CW-1]) begin
                            wr_en = 1'b1;
                        end
                        if (wcnt_reg == LAST_IDX) begin
                            state_next = IDLE;
                            wcnt_next  = '0;
                            if (state_reg == FILL) begin
                                set_full     = 1'b1;
                                wr_bank_next = ~wr_bank_reg;
                            end
                        end else begin
                            wcnt_next = wcnt_reg + CW'(1);
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Writer and reader always target different banks when both complete,
    // so the clear and set never collide on one flag.
    always_comb begin
        full_next = full_reg;
        if (rd_last) begin
            full_next[rd_bank_reg] = 1'b0;
        end
        if (set_full) begin
            full_next[wr_bank_reg] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            wcnt_reg      <= '0;
            wr_bank_reg   <= 1'b0;
            rd_bank_reg   <= 1'b0;
            raddr_reg     <= '0;
            full_reg      <= 2'b00;
            y_zero_reg    <= 1'b1;
            out_valid_reg <= 1'b0;
            underrun_reg  <= 1'b0;
            overrun_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
            blk_rdy_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            wcnt_reg      <= wcnt_next;
            wr_bank_reg   <= wr_bank_next;
            rd_bank_reg   <= rd_bank_next;
            raddr_reg     <= raddr_next;
            full_reg      <= full_next;
            out_valid_reg <= rd_fire;
            underrun_reg  <= rd_under;
            overrun_reg   <= overrun_next;
            frame_err_reg <= frame_err_next;
            blk_rdy_reg   <= |full_next;
            if (rd_fire) begin
                y_zero_reg <= 1'b0;
            end else if (rd_under) begin
                y_zero_reg <= 1'b1;
            end
        end
    end

    // ---------------- buffer RAM ----------------
    // Kept free of reset so it maps onto block RAM; the output is forced
    // to zero by y_zero_reg instead of clearing the read register.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wr_bank_reg, wcnt_reg[AW-1:0]}] <= {x_i, x_q};
        end
    end

    always_ff @(posedge clk) begin
        if (rd_fire) begin
            rd_data_reg <= mem[{rd_bank_reg, raddr_reg}];
        end
    end

    assign y_i       = y_zero_reg ? '0 : rd_data_reg[2*WIDTH-1:WIDTH];
    assign y_q       = y_zero_reg ? '0 : rd_data_reg[WIDTH-1:0];
    assign out_valid = out_valid_reg;
    assign underrun  = underrun_reg;
    assign overrun   = overrun_reg;
    assign frame_err = frame_err_reg;
    assign blk_rdy   = blk_rdy_reg;

endmodule

// File: tb/tb_ols_deblock.sv
// Testbench for ols_deblock with BLK_LEN=4, WIDTH=16. Stimulus pushes the
// expected response of every out_req into a scoreboard queue; a monitor on
// the falling clock edge pops and compares whenever the DUT reports
// out_valid or underrun, including the exact one-clock latency.
module tb_ols_deblock;

    localparam int N = 4;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] x_i = '0, x_q = '0;
    logic         in_valid = 1'b0, in_start = 1'b0, out_req = 1'b0;
    logic [W-1:0] y_i, y_q;
    logic         out_valid, blk_rdy, overrun, underrun, frame_err;

    ols_deblock #(.BLK_LEN(N), .WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .x_i(x_i), .x_q(x_q), .in_valid(in_valid), .in_start(in_start),
        .out_req(out_req),
        .y_i(y_i), .y_q(y_q), .out_valid(out_valid), .blk_rdy(blk_rdy),
        .overrun(overrun), .underrun(underrun), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           cyc;
        bit           und;
        logic [W-1:0] i;
        logic [W-1:0] q;
    } exp_t;
    exp_t sbq[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (reset) begin
            if (out_valid || underrun) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: out_valid=%0b underrun=%0b y=%0d/%0d with nothing expected (cycle %0d)",
                             out_valid, underrun, y_i, y_q, cyc);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    if (cyc != e.cyc || underrun != e.und || out_valid == e.und ||
                        y_i != e.i || y_q != e.q) begin
                        errors++;
                        $display("FAIL response: got cycle %0d valid=%0b und=%0b y=%0d/%0d expected cycle %0d und=%0b y=%0d/%0d",
                                 cyc, out_valid, underrun, y_i, y_q, e.cyc, e.und, e.i, e.q);
                    end else begin
                        $display("resp cycle %0d und=%0b y_i=%0d y_q=%0d ok", cyc, underrun, y_i, y_q);
                    end
                end
            end else if (sbq.size() > 0 && sbq[0].cyc < cyc) begin
                exp_t e;
                e = sbq.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_response: got nothing expected und=%0b y=%0d/%0d at cycle %0d",
                         e.und, e.i, e.q, e.cyc);
            end
        end
    end

    // One clock of stimulus; an out_req pushes its expected response.
    task automatic step(input bit v, input bit st, input logic [W-1:0] xi, input logic [W-1:0] xq,
                        input bit req, input bit und, input logic [W-1:0] ei, input logic [W-1:0] eq);
        exp_t e;
        in_valid = v; in_start = st; x_i = xi; x_q = xq; out_req = req;
        if (req) begin
            e.cyc = cyc + 1; e.und = und; e.i = ei; e.q = eq;
            sbq.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_start = 1'b0; out_req = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    task automatic send_frame(input logic [W-1:0] bi, input logic [W-1:0] bq);
        for (int k = 0; k < 2*N; k++) step(1, k == 0, bi + W'(k), bq + W'(k), 0, 0, '0, '0);
    endtask

    // Request one sample expecting data, then leave one idle clock.
    task automatic read(input logic [W-1:0] ei, input logic [W-1:0] eq);
        step(0, 0, '0, '0, 1, 0, ei, eq);
        idle(1);
    endtask

    task automatic read_block(input logic [W-1:0] bi, input logic [W-1:0] bq);
        for (int k = N; k < 2*N; k++) read(bi + W'(k), bq + W'(k));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_y_i"}, int'(y_i), 0);
        chk({tag, "_y_q"}, int'(y_q), 0);
        chk({tag, "_out_valid"}, int'(out_valid), 0);
        chk({tag, "_blk_rdy"}, int'(blk_rdy), 0);
        chk({tag, "_overrun"}, int'(overrun), 0);
        chk({tag, "_underrun"}, int'(underrun), 0);
        chk({tag, "_frame_err"}, int'(frame_err), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b1;
        idle(2);

        // ---- underrun with nothing loaded ----
        step(0, 0, '0, '0, 1, 1, '0, '0);
        idle(2);

        // ---- basic frame: x_i=0..7, x_q=100..107 ----
        for (int k = 0; k < 2*N; k++) begin
            step(1, k == 0, W'(k), W'(100 + k), 0, 0, '0, '0);
            if (k == 2*N-2) chk("blk_rdy_before_last", int'(blk_rdy), 0);
        end
        chk("blk_rdy_after_last", int'(blk_rdy), 1);
        for (int k = N; k < 2*N; k++) begin
            step(0, 0, '0, '0, 1, 0, W'(k), W'(100 + k));
            chk($sformatf("blk_rdy_read%0d", k - N), int'(blk_rdy), (k == 2*N-1) ? 0 : 1);
            idle(1);
        end

        // ---- three back-to-back frames, C dropped ----
        send_frame(16'h0200, 16'h0300);
        send_frame(16'h0400, 16'h0500);
        for (int k = 0; k < 2*N; k++) begin
            step(1, k == 0, 16'h0600 + W'(k), 16'h0700 + W'(k), 0, 0, '0, '0);
            if (k < 2) chk($sformatf("overrun_c%0d", k), int'(overrun), (k == 0) ? 1 : 0);
            chk($sformatf("frame_err_c%0d", k), int'(frame_err), 0);
        end
        idle(2);
        read_block(16'h0200, 16'h0300);
        read_block(16'h0400, 16'h0500);

        // ---- in_start at index 5 restarts the frame ----
        for (int k = 0; k < 5; k++) step(1, k == 0, 16'h0800 + W'(k), 16'h0880 + W'(k), 0, 0, '0, '0);
        for (int k = 0; k < 2*N; k++) begin
            step(1, k == 0, 16'h0900 + W'(k), 16'h0980 + W'(k), 0, 0, '0, '0);
            if (k < 2) chk($sformatf("frame_err_d%0d", k), int'(frame_err), (k == 0) ? 1 : 0);
            if (k == 0) chk("overrun_d0", int'(overrun), 0);
        end
        idle(1);
        read_block(16'h0900, 16'h0980);
        idle(3);

        // ---- gapped fill of bank 1 while bank 0 drains; both finish together ----
        send_frame(16'h0A00, 16'h0A80);
        for (int c = 0; c < 4*N; c++) begin
            bit rq;
            rq = (c >= 8) && (c % 2 == 0);
            step(c % 2 == 0, c == 0, 16'h0B00 + W'(c/2), 16'h0B80 + W'(c/2),
                 rq, 0, 16'h0A00 + W'(N + (c-8)/2), 16'h0A80 + W'(N + (c-8)/2));
            chk($sformatf("overrun_gap%0d", c), int'(overrun), 0);
        end
        chk("blk_rdy_after_swap", int'(blk_rdy), 1);
        read_block(16'h0B00, 16'h0B80);
        chk("blk_rdy_after_gap_reads", int'(blk_rdy), 0);

        // ---- reset mid-read and mid-fill ----
        send_frame(16'h0C00, 16'h0C80);
        read(16'h0C00 + W'(N), 16'h0C80 + W'(N));
        read(16'h0C00 + W'(N+1), 16'h0C80 + W'(N+1));
        for (int k = 0; k < 3; k++) step(1, k == 0, 16'h0D00 + W'(k), 16'h0D80 + W'(k), 0, 0, '0, '0);
        chk("pre_reset_y_i", int'(y_i), 16'h0C00 + N + 1);
        @(negedge clk); #2;
        reset = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        idle(2);
        send_frame(16'h0E00, 16'h0E80);
        read_block(16'h0E00, 16'h0E80);

        // ---- final underrun after bank drained: y forced to 0 ----
        step(0, 0, '0, '0, 1, 1, '0, '0);
        idle(4);
        chk("scoreboard_empty", sbq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ols_deblock.md
Name: ols_deblock

Overview:
- Output-side framer for the overlap-save FFT block LMS datapath, and the counterpart of the input block concatenator.
- Accepts 2N-sample complex frames from the IFFT at the processing clock.
- Discards the first N samples of each frame, which are the circular-convolution aliased half.
- Stores the last N samples in a ping-pong buffer and replays them one per sample request, so the filter output is delivered at the input sample rate.

Parameters:
- BLK_LEN, 32: N, the valid samples per block; the input frame length is 2*BLK_LEN. Must be a power of 2, minimum 2.
- WIDTH, 16: bit width of each I and Q sample.

Ports:
- clk, input, 1: processing clock (2x sample rate or faster).
- reset, input, 1: asynchronous, active-low reset.
- x_i, input, WIDTH: IFFT output, in-phase.
- x_q, input, WIDTH: IFFT output, quadrature.
- in_valid, input, 1: x_i/x_q carry a sample this cycle.
- in_start, input, 1: marks frame sample index 0; qualified by in_valid.
- out_req, input, 1: single-cycle sample-rate strobe requesting one output sample.
- y_i, output, WIDTH: block output, in-phase.
- y_q, output, WIDTH: block output, quadrature.
- out_valid, output, 1: y_i/y_q valid; 1-cycle pulse.
- blk_rdy, output, 1: at least one buffer bank is full.
- overrun, output, 1: 1-cycle pulse; incoming frame dropped.
- underrun, output, 1: 1-cycle pulse; out_req arrived with no full bank.
- frame_err, output, 1: 1-cycle pulse; in_start arrived mid-frame.

Behaviour:
- Reset (reset=0, async):
  - All outputs 0.
  - Both banks empty; wr_bank=0, rd_bank=0.
  - Write FSM goes to IDLE; read address goes to 0.
  - Buffer RAM contents are don't-care.
- Write FSM, states IDLE / FILL / DROP:
  - IDLE: ignores in_valid without in_start.
  - IDLE, on in_valid&in_start: if bank[wr_bank] is empty, go to FILL with wcnt=1. If it is full, pulse overrun and go to DROP with wcnt=1.
  - A bank freed by the reader in the same cycle counts as empty.
  - FILL, each in_valid sample at index wcnt (0..2N-1): indices 0..N-1 are discarded; indices N..2N-1 are written to bank[wr_bank] at address wcnt-N.
  - FILL, on writing index 2N-1: set full[wr_bank], toggle wr_bank, return to IDLE.
  - DROP: counts samples without writing; returns to IDLE after index 2N-1.
  - FILL or DROP, in_valid&in_start: pulse frame_err, abandon the partial frame (bank stays empty), and treat the sample as index 0 of a new frame using the IDLE rules.
  - in_valid=0 cycles hold wcnt; there is no timeout.
- Read path:
  - On out_req with full[rd_bank]=1: the next cycle drives y = bank[rd_bank][raddr] and out_valid=1, so latency is exactly 1 clk. raddr then increments.
  - On the read of raddr=N-1: clear full[rd_bank], toggle rd_bank, set raddr=0.
  - On out_req with no full bank: pulse underrun the next cycle, with out_valid=0 and y=0.
  - y holds its last value when out_valid=0, except after an underrun, when y=0.
- Timing and concurrency:
  - full[b] set at the edge of the last write is visible to out_req in the following cycle.
  - A write completing on one bank and a read completing on the other in the same cycle are both honoured.
- blk_rdy = full[0] | full[1], registered.
- Arithmetic: none. Samples pass bit-exact; there is no scaling or rounding.
- RAM: 2 banks x N x 2*WIDTH, 1 write port and 1 read port, synchronous read.

Test Plan:
- Bench overrides BLK_LEN=4. Send one 8-sample frame with x_i=0..7, x_q=100..107, in_valid continuous; then 4 out_req spaced 2 clk. Required: y_i=4,5,6,7 and y_q=104..107, each out_valid exactly 1 clk after its out_req; blk_rdy 1 from the clk after sample 7 until the 4th read.
- Reset: out_req with no frame loaded -> underrun pulse 1 clk later, out_valid=0, y=0.
- Three back-to-back frames (A, B, C) with no reads -> A and B stored; overrun at C's start; C dropped. Then 8 reads return A[4..7] followed by B[4..7].
- in_start asserted at index 5 of a frame -> frame_err pulse. The new 8-sample frame is stored and read back correctly; the partial frame produces no output.
- Gapped input (in_valid toggling 1/0) combined with the last read of bank 0 in the same cycle that the final write to bank 1 completes -> no data loss, no overrun, reads continue seamlessly into bank 1.
- Assert reset mid-fill and mid-read -> all outputs 0 immediately. After release, a fresh frame is read back correctly starting from bank 0, address 0.
